// File: rtl/frame_pkg.sv
// Shared sizing, window record and FSM state type for the frame-border overlay scheduler.
package frame_pkg;
  localparam int unsigned NUM_WIN      = 4;
  localparam int unsigned IDX_W        = $clog2(NUM_WIN);
  localparam int unsigned COORD_W      = 8;
  localparam int unsigned CNT_W        = 10;
  localparam int unsigned TILE_SHIFT   = 2;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
  } win_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;
endpackage

// File: rtl/frame_window_sched_if.sv
// Pixel counters, host shadow-bank writes, commit control and overlay draw outputs.
interface frame_window_sched_if;
  import frame_pkg::*;

  logic [CNT_W-1:0]   counter_x;
  logic [CNT_W-1:0]   counter_y;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [IDX_W-1:0]   cfg_idx;
  logic               cfg_en;
  logic [COORD_W-1:0] cfg_x0;
  logic [COORD_W-1:0] cfg_y0;
  logic [COORD_W-1:0] cfg_x1;
  logic [COORD_W-1:0] cfg_y1;
  logic               commit_req;
  logic               commit_pending;
  logic               commit_done;
  logic               draw_frame;
  logic [IDX_W-1:0]   draw_idx;

  modport slave (
    input  counter_x, counter_y, cfg_valid, cfg_idx, cfg_en,
           cfg_x0, cfg_y0, cfg_x1, cfg_y1, commit_req,
    output cfg_ready, commit_pending, commit_done, draw_frame, draw_idx
  );

  modport master (
    output counter_x, counter_y, cfg_valid, cfg_idx, cfg_en,
           cfg_x0, cfg_y0, cfg_x1, cfg_y1, commit_req,
    input  cfg_ready, commit_pending, commit_done, draw_frame, draw_idx
  );
endinterface

// File: rtl/frame_win_hit.sv
// Per-window border hit test against the active bank, resolved by fixed priority (index 0 wins).
module frame_win_hit
  import frame_pkg::*;
(
  input  win_t [NUM_WIN-1:0] i_wins,
  input  logic [COORD_W-1:0] i_tx,
  input  logic [COORD_W-1:0] i_ty,
  output logic               o_hit_c,
  output logic [IDX_W-1:0]   o_idx_c
);
  logic [NUM_WIN-1:0] w_hit;

  // Inclusive-range check excludes degenerate windows (x0>x1 or y0>y1) on its own.
  always_comb begin
    w_hit = '0;
    for (int unsigned k = 0; k < NUM_WIN; k++) begin
      w_hit[k] = i_wins[k].en
              && (i_wins[k].x0 <= i_tx) && (i_tx <= i_wins[k].x1)
              && (i_wins[k].y0 <= i_ty) && (i_ty <= i_wins[k].y1)
              && ((i_tx == i_wins[k].x0) || (i_tx == i_wins[k].x1) ||
                  (i_ty == i_wins[k].y0) || (i_ty == i_wins[k].y1));
    end
  end

  always_comb begin
    o_hit_c = 1'b0;
    o_idx_c = '0;
    for (int unsigned k = 0; k < NUM_WIN; k++) begin
      if (w_hit[k] && !o_hit_c) begin
        o_hit_c = 1'b1;
        o_idx_c = IDX_W'(k);
      end
    end
  end
endmodule

// File: rtl/frame_window_sched.sv
// Overlay window scheduler: shadow/active window banks, vblank-synchronous commit, 2-stage draw pipeline.
module frame_window_sched
  import frame_pkg::*;
#(
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_window_sched_if.slave  bus
);
  state_t               r_state;
  state_t               w_state_nxt;
  win_t [NUM_WIN-1:0]   r_shadow;
  win_t [NUM_WIN-1:0]   r_active;
  win_t                 w_cfg_win;
  logic [IDX_W-1:0]     r_cidx;
  logic                 r_sticky;
  logic                 w_last;
  logic                 w_vb;
  logic                 w_cfg_fire;
  logic [COORD_W-1:0]   r_tx;
  logic [COORD_W-1:0]   r_ty;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_hit_idx;
  logic                 r_cfg_ready;
  logic                 r_pending;
  logic                 r_done;
  logic                 r_draw;
  logic [IDX_W-1:0]     r_draw_idx;

  assign w_vb       = (bus.counter_y == CNT_W'(V_ACTIVE)) && (bus.counter_x == '0);
  assign w_cfg_fire = bus.cfg_valid && r_cfg_ready;
  assign w_cfg_win  = '{en: bus.cfg_en, x0: bus.cfg_x0, y0: bus.cfg_y0,
                        x1: bus.cfg_x1, y1: bus.cfg_y1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Requests arriving during a copy are remembered and served at the next vblank.
  always_comb begin
    w_state_nxt = r_state;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.commit_req) w_state_nxt = w_vb ? ST_COMMIT : ST_PENDING;
      end
      ST_PENDING: begin
        if (w_vb) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (r_cidx == IDX_W'(NUM_WIN - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = (r_sticky || bus.commit_req) ? ST_PENDING : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cfg_ready <= 1'b0;
      r_pending   <= 1'b0;
      r_done      <= 1'b0;
      r_sticky    <= 1'b0;
      r_cidx      <= '0;
    end else begin
      r_cfg_ready <= (w_state_nxt != ST_COMMIT);
      r_pending   <= (w_state_nxt == ST_PENDING);
      r_done      <= w_last;
      r_sticky    <= (r_state == ST_COMMIT) && !w_last && (r_sticky || bus.commit_req);
      r_cidx      <= ((r_state == ST_COMMIT) && !w_last) ? r_cidx + IDX_W'(1) : '0;
    end
  end

  // Shadow write lands before the index-0 copy, so a write on the vblank cycle is committed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (w_cfg_fire) r_shadow[bus.cfg_idx] <= w_cfg_win;
      if (r_state == ST_COMMIT) r_active[r_cidx] <= r_shadow[r_cidx];
    end
  end

  frame_win_hit u_hit (
    .i_wins  (r_active),
    .i_tx    (r_tx),
    .i_ty    (r_ty),
    .o_hit_c (w_hit),
    .o_idx_c (w_hit_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx       <= '0;
      r_ty       <= '0;
      r_draw     <= 1'b0;
      r_draw_idx <= '0;
    end else begin
      r_tx       <= bus.counter_x[CNT_W-1:TILE_SHIFT];
      r_ty       <= bus.counter_y[CNT_W-1:TILE_SHIFT];
      r_draw     <= w_hit;
      r_draw_idx <= w_hit_idx;
    end
  end

  assign bus.cfg_ready      = r_cfg_ready;
  assign bus.commit_pending = r_pending;
  assign bus.commit_done    = r_done;
  assign bus.draw_frame     = r_draw;
  assign bus.draw_idx       = r_draw_idx;
endmodule

// File: doc/frame_window_sched.md
Name: frame_window_sched

Overview:
- Scheduler/arbiter for the frame-border overlay.
- Holds NUM_WIN rectangle windows in 4x4-pixel tile coordinates and accepts software/host reconfiguration into a shadow bank.
- Commits the shadow bank to the active bank only during vertical blanking, so windows never tear mid-frame.
- Per pixel, picks the highest-priority window whose border covers the pixel and drives the overlay draw strobe consumed by the pixel mux.

Parameters:
- NUM_WIN, 4, number of windows; index 0 has highest priority.
- IDX_W, 2, width of window index; must equal clog2(NUM_WIN).
- COORD_W, 8, tile coordinate width (pixel counter >> 2).
- V_ACTIVE, 480, first non-visible line; start of vertical blank.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-low reset.
- counter_x  in  10  horizontal pixel counter.
- counter_y  in  10  vertical line counter.
- cfg_valid  in  1  shadow write request.
- cfg_ready  out  1  shadow write accepted when cfg_valid & cfg_ready.
- cfg_idx  in  IDX_W  target window.
- cfg_en  in  1  window enable.
- cfg_x0, cfg_y0, cfg_x1, cfg_y1  in  COORD_W each  inclusive corners, tile units.
- commit_req  in  1  single-cycle pulse: apply shadow bank at next vblank.
- commit_pending  out  1  commit requested, not yet applied.
- commit_done  out  1  single-cycle pulse after last window is copied.
- draw_frame  out  1  pixel lies on an enabled window border.
- draw_idx  out  IDX_W  winning window index; 0 when draw_frame=0.

Behaviour:
- Reset (rst=0, async):
  - Shadow and active banks cleared: en=0, coordinates 0.
  - FSM to IDLE; draw_frame=0, draw_idx=0, commit_pending=0, commit_done=0.
  - cfg_ready=1 from the first clock after release.
- Draw pipeline, latency 2 cycles from counter_x/counter_y to draw_frame/draw_idx:
  - S1 registers tx=counter_x[9:2], ty=counter_y[9:2].
  - S2 computes per-window hit from the active bank and registers the result.
  - Hit = en & x0<=tx<=x1 & y0<=ty<=y1 & (tx==x0 | tx==x1 | ty==y0 | ty==y1).
  - Degenerate window (x0>x1 or y0>y1) never hits. Single-tile window (x0==x1, y0==y1) hits one tile.
  - Priority: lowest index wins on overlap.
- Vblank strobe vb: 1 cycle when raw counter_y==V_ACTIVE and counter_x==0.
- FSM states IDLE, PENDING, COMMIT:
  - IDLE: commit_req & !vb -> PENDING. commit_req & vb -> COMMIT.
  - PENDING: commit_pending=1; vb -> COMMIT; further commit_req ignored (merged).
  - COMMIT:
    - Copies shadow[k] to active[k], one window per cycle, k = 0..NUM_WIN-1; occupies NUM_WIN cycles.
    - cfg_ready=0 for the whole state.
    - After the last copy: commit_done pulses for 1 cycle and FSM -> IDLE.
    - commit_req during COMMIT sets a sticky flag; on exit FSM -> PENDING instead of IDLE, so the request is served at the next vblank.
- Config writes:
  - Accepted in IDLE and PENDING; shadow updated on the following edge.
  - A write and commit_req in the same cycle: the write is included in the commit.
  - A write accepted in the cycle vb enters COMMIT is also included, because the shadow write precedes the copy of index 0.
- Active bank changes only in COMMIT. Draw output during blank lines is don't-care, but must follow the hit rule above.
- Reset mid-COMMIT: partial copy is discarded, all banks cleared, no commit_done pulse.

Decomposition:
- Shared package frame_pkg:
  - Window record typedef {en, x0, y0, x1, y1}.
  - FSM state enum.
  - TILE_SHIFT=2, V_ACTIVE default.
- One sub-module: frame_win_hit. Combinational per-window border test plus priority encoder, instanced once in S2.

Test Plan:
- Reset, then counters sweep a full 640x525 frame with no config -> draw_frame=0 everywhere; cfg_ready=1; draw_idx=0.
- Write win0 {en=1,1,1,10,5}, commit_req at line 100 -> commit_pending=1 until line 480, x=0. Then commit_done 4 cycles later. Next frame: draw_frame=1 at pixel (4,4) and (40,12). Pixel (8,8) stays 0 (interior). Output is 2 cycles after the counter.
- win0 {1,0,0,20,20}, win2 {1,0,0,20,20} overlapping -> draw_idx=0 on shared border. Then disable win0 and commit -> draw_idx=2 from the next frame.
- Degenerate win1 {1,10,5,3,8} -> never hits. Single-tile win3 {1,7,7,7,7} -> exactly pixels x,y in 28..31 assert draw_frame.
- Hold cfg_valid across a commit -> cfg_ready low exactly 4 cycles, no write lost. A second commit_req mid-COMMIT -> commit_pending=1 after commit_done, applied at the following vblank.
- Drop rst during COMMIT cycle 2 -> draw_frame=0, commit_pending=0, no commit_done. After release, all windows disabled.
